// File: rtl/tx_phase_nco.sv
// Phase-accumulator NCO driving the TX channel CORDIC phase input, with a
// valid/ready FTW load path and a linear FTW sweep engine.
// Optional build macro TX_NCO_WRAP_SYNC_EN: defer FTW changes to accumulator wraps.
module tx_phase_nco #(
    parameter int AW   = 32,
    parameter int PW_I = 19,
    parameter int CW   = 16
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic [AW-1:0]   ftw_in,
    input  logic            ftw_valid,
    output logic            ftw_ready,
    input  logic [PW_I-1:0] phase_offset,
    input  logic            sweep_start,
    input  logic [AW-1:0]   sweep_step,
    input  logic [CW-1:0]   sweep_len,
    output logic            sweep_busy,
    output logic [AW-1:0]   ftw_cur,
    output logic [PW_I-1:0] phase_out,
    output logic            phase_wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_sum;
    logic            acc_carry;
    logic [AW-1:0]   ftw_pend;
    logic [CW-1:0]   cnt;
    logic            wrap_d;
    logic            apply_pend;
    logic            sweep_req;

    assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, ftw_cur};
    assign sweep_req = sweep_start && (sweep_len != '0);

    // With wrap sync, a zero FTW never carries, so it is replaced immediately.
    always_comb begin
`ifdef TX_NCO_WRAP_SYNC_EN
        apply_pend = acc_carry || (ftw_cur == '0);
`else
        apply_pend = 1'b1;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ftw_valid) begin
                    state_nxt = PEND;
                end else if (sweep_req) begin
                    state_nxt = SWEEP;
                end
            end
            PEND: begin
                if (apply_pend) begin
                    state_nxt = IDLE;
                end
            end
            SWEEP: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ftw_ready  = (state == IDLE) && !rst;
        sweep_busy = (state == SWEEP);
    end

    // The accumulator never stops, so retuning keeps the phase continuous.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            acc        <= '0;
            wrap_d     <= 1'b0;
            phase_wrap <= 1'b0;
            phase_out  <= '0;
            ftw_cur    <= '0;
            ftw_pend   <= '0;
            cnt        <= '0;
        end else begin
            acc        <= acc_sum;
            wrap_d     <= acc_carry;
            phase_wrap <= wrap_d;
            phase_out  <= acc[AW-1 -: PW_I] + phase_offset;
            case (state)
                IDLE: begin
                    if (ftw_valid) begin
                        ftw_pend <= ftw_in;
                    end else if (sweep_req) begin
                        cnt <= sweep_len;
                    end
                end
                PEND: begin
                    if (apply_pend) begin
                        ftw_cur <= ftw_pend;
                    end
                end
                SWEEP: begin
                    ftw_cur <= ftw_cur + sweep_step;
                    cnt     <= cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_phase_nco.sv
// Scoreboard bench for tx_phase_nco: a cycle reference model pushes expected
// outputs per edge, a monitor pops and compares them on the falling edge.
module tb_tx_phase_nco;

    localparam int AW = 32;
    localparam int PW = 19;
    localparam int CW = 16;
    localparam longint unsigned AMASK = (64'd1 << AW) - 1;
    localparam longint unsigned PMASK = (64'd1 << PW) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_SWEEP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ftw_in;
    logic          ftw_valid;
    logic          ftw_ready;
    logic [PW-1:0] phase_offset;
    logic          sweep_start;
    logic [AW-1:0] sweep_step;
    logic [CW-1:0] sweep_len;
    logic          sweep_busy;
    logic [AW-1:0] ftw_cur;
    logic [PW-1:0] phase_out;
    logic          phase_wrap;

    tx_phase_nco #(.AW(AW), .PW_I(PW), .CW(CW)) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .ftw_in      (ftw_in),
        .ftw_valid   (ftw_valid),
        .ftw_ready   (ftw_ready),
        .phase_offset(phase_offset),
        .sweep_start (sweep_start),
        .sweep_step  (sweep_step),
        .sweep_len   (sweep_len),
        .sweep_busy  (sweep_busy),
        .ftw_cur     (ftw_cur),
        .phase_out   (phase_out),
        .phase_wrap  (phase_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned ftw;
        longint unsigned phase;
        bit              wrap;
        bit              busy;
        bit              idle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mdl_e;
    int checks = 0;
    int errors = 0;

    longint unsigned m_acc, m_ftw, m_pend, m_phase, m_sum;
    bit              m_wrap, m_carry, m_c;
    int              m_mode, m_left;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: what every register should hold after each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0; m_ftw = 0; m_pend = 0; m_phase = 0;
            m_wrap = 0; m_carry = 0; m_mode = M_IDLE; m_left = 0;
        end else begin
            m_sum   = m_acc + m_ftw;
            m_c     = (m_sum >> AW) != 0;
            m_phase = ((m_acc >> (AW - PW)) + longint'(phase_offset)) & PMASK;
            m_wrap  = m_carry;
            m_carry = m_c;
            case (m_mode)
                M_IDLE: begin
                    if (ftw_valid) begin
                        m_pend = longint'(ftw_in);
                        m_mode = M_PEND;
                    end else if (sweep_start && sweep_len != 0) begin
                        m_left = int'(sweep_len);
                        m_mode = M_SWEEP;
                    end
                end
                M_PEND: begin
`ifdef TX_NCO_WRAP_SYNC_EN
                    if (m_c || m_ftw == 0) begin
                        m_ftw  = m_pend;
                        m_mode = M_IDLE;
                    end
`else
                    m_ftw  = m_pend;
                    m_mode = M_IDLE;
`endif
                end
                default: begin
                    m_ftw  = (m_ftw + longint'(sweep_step)) & AMASK;
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            endcase
            m_acc = m_sum & AMASK;
        end
        mdl_e.ftw   = m_ftw;
        mdl_e.phase = m_phase;
        mdl_e.wrap  = m_wrap;
        mdl_e.busy  = (m_mode == M_SWEEP);
        mdl_e.idle  = (m_mode == M_IDLE);
        exp_q.push_back(mdl_e);
    end

    // Monitor: compares one expectation per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_ftw_cur", ftw_cur, mon_e.ftw);
            checkOutput("sb_phase_out", phase_out, mon_e.phase);
            checkOutput("sb_phase_wrap", phase_wrap, mon_e.wrap);
            checkOutput("sb_sweep_busy", sweep_busy, mon_e.busy);
            checkOutput("sb_ftw_ready", ftw_ready, mon_e.idle && !rst);
        end
    end

    task automatic applyStimulus(input logic r, input logic v, input logic [AW-1:0] f,
                                 input logic s, input logic [AW-1:0] st,
                                 input logic [CW-1:0] len, input logic [PW-1:0] off);
        rst = r; ftw_valid = v; ftw_in = f; sweep_start = s;
        sweep_step = st; sweep_len = len; phase_offset = off;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, ftw_in, 1'b0, sweep_step, sweep_len, phase_offset);
    endtask

    logic [PW-1:0]  prev_phase;
    logic [PW-1:0]  diff_phase;
    int             wrap_first, wrap_last, wrap_n, wait_n;
    logic           r_rst, r_v, r_s;
    logic [AW-1:0]  r_step;
    logic [PW-1:0]  r_off;

    initial begin
        rst = 1'b1; ftw_valid = 1'b1; ftw_in = 32'h1234_5678; sweep_start = 1'b0;
        sweep_step = '0; sweep_len = '0; phase_offset = '0;

        // Reset held with a pending request: nothing may be accepted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b0, '0, '0, '0);
            checkOutput("rst_phase_out", phase_out, 0);
            checkOutput("rst_phase_wrap", phase_wrap, 0);
            checkOutput("rst_ftw_ready", ftw_ready, 0);
        end
        applyStimulus(1'b0, 1'b0, 32'h1234_5678, 1'b0, '0, '0, '0);
        checkOutput("ready_after_rst", ftw_ready, 1);
        checkOutput("no_transfer_in_rst", ftw_cur, 0);

        // Static offset with zero FTW
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 19'h40000);
        idleCycles(1);
        checkOutput("offset_phase", phase_out, 19'h40000);
        idleCycles(1);
        checkOutput("offset_phase_hold", phase_out, 19'h40000);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
        idleCycles(1);

`ifndef TX_NCO_WRAP_SYNC_EN
        applyStimulus(1'b0, 1'b1, 32'h0100_0000, 1'b0, '0, '0, '0);
        checkOutput("load_ready_low", ftw_ready, 0);
        checkOutput("load_ftw_old", ftw_cur, 0);
        applyStimulus(1'b0, 1'b0, 32'h0100_0000, 1'b0, '0, '0, '0);
        checkOutput("load_ftw_new", ftw_cur, 32'h0100_0000);
        checkOutput("load_ready_back", ftw_ready, 1);
        idleCycles(2);
        prev_phase = phase_out;
        idleCycles(1);
        diff_phase = phase_out - prev_phase;
        checkOutput("phase_step", diff_phase, 2048);
        wrap_n = 0; wrap_first = 0; wrap_last = 0;
        for (int i = 0; i < 600; i++) begin
            idleCycles(1);
            if (phase_wrap) begin
                if (wrap_n == 0) wrap_first = i;
                wrap_last = i;
                wrap_n++;
            end
        end
        checkOutput("wrap_count_min", wrap_n >= 2, 1);
        checkOutput("wrap_period", wrap_last - wrap_first, 256 * (wrap_n - 1));
`else
        applyStimulus(1'b0, 1'b1, 32'h4000_0000, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, 32'h4000_0000, 1'b0, '0, '0, '0);
        checkOutput("zero_ftw_apply", ftw_cur, 32'h4000_0000);
        applyStimulus(1'b0, 1'b1, 32'h0800_0000, 1'b0, '0, '0, '0);
        wait_n = 0;
        while (wait_n < 6 && ftw_cur != 32'h0800_0000) begin
            checkOutput("sync_ftw_old", ftw_cur, 32'h4000_0000);
            checkOutput("sync_ready_low", ftw_ready, 0);
            applyStimulus(1'b0, 1'b0, 32'h0800_0000, 1'b0, '0, '0, '0);
            wait_n++;
        end
        checkOutput("sync_latency", (wait_n >= 1 && wait_n <= 4), 1);
        checkOutput("sync_ftw_new", ftw_cur, 32'h0800_0000);
`endif

        // Sweep of four steps from zero
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h0001_0000, 16'd4, '0);
        checkOutput("sweep_busy_rise", sweep_busy, 1);
        checkOutput("sweep_ready_low", ftw_ready, 0);
        checkOutput("sweep_ftw_start", ftw_cur, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0001_0000, 16'd4, '0);
            checkOutput("sweep_ftw_step", ftw_cur, 32'h0001_0000 * i);
            checkOutput("sweep_busy_len", sweep_busy, i < 4);
            checkOutput("sweep_ready", ftw_ready, i == 4);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h0001_0000, 16'd0, '0);
        checkOutput("sweep_len0_busy", sweep_busy, 0);
        checkOutput("sweep_len0_ftw", ftw_cur, 32'h0004_0000);

        // Collision: the FTW load wins
        applyStimulus(1'b0, 1'b1, 32'h0200_0000, 1'b1, 32'h0001_0000, 16'd4, '0);
        checkOutput("collide_ready", ftw_ready, 0);
        checkOutput("collide_busy", sweep_busy, 0);
        applyStimulus(1'b0, 1'b0, 32'h0200_0000, 1'b0, 32'h0001_0000, 16'd4, '0);
        checkOutput("collide_busy_after", sweep_busy, 0);

        // Reset aborts a running sweep
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h0001_0000, 16'd4, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 32'h0001_0000, 16'd4, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 32'h0001_0000, 16'd4, '0);
        checkOutput("abort_ftw", ftw_cur, 0);
        checkOutput("abort_busy", sweep_busy, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);

        // Randomized traffic against the model
        r_off = '0;
        for (int i = 0; i < 1500; i++) begin
            r_rst  = ($urandom_range(0, 99) == 0);
            r_v    = ($urandom_range(0, 7) == 0);
            r_s    = ($urandom_range(0, 5) == 0);
            r_step = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 255) << 12);
            if ($urandom_range(0, 15) == 0) r_off = PW'($urandom);
            applyStimulus(r_rst, r_v, $urandom, r_s, r_step, CW'($urandom_range(0, 8)), r_off);
        end
        idleCycles(1);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
